// File: rtl/xt_lb_bridge_pkg.sv
// Shared types for the high-speed to low-speed bus bridge: host request,
// selects, low-speed strobe bundle, bridge FSM states and write-buffer entry.
package XT_BUS;

   localparam int          LB_ADDR_WIDTH    = 16;
   localparam logic [31:0] LB_TIMEOUT_RDATA = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [31:0] raddr;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [1:0]  write_width;
   } hb_slave_t;

   typedef struct packed {
      logic ren;
      logic wen;
   } sel_t;

   typedef struct packed {
      logic                     ren;
      logic                     wen;
      logic [LB_ADDR_WIDTH-1:0] addr;
      logic [31:0]              wdata;
      logic [1:0]               write_width;
   } lb_slave_t;

   typedef enum logic [1:0] {
      LB_IDLE  = 2'd0,
      LB_WRITE = 2'd1,
      LB_READ  = 2'd2
   } lb_bridge_state_e;

   typedef struct packed {
      logic [LB_ADDR_WIDTH-1:0] addr;
      logic [31:0]              wdata;
      logic [1:0]               write_width;
   } wbuf_entry_t;

   localparam int WBUF_W = $bits(wbuf_entry_t);

endpackage

// File: rtl/xt_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; DEPTH must be a power of two so
// the pointers wrap by natural overflow.
module xt_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign data_o  = mem_q[rptr_q];

   // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/xt_lb_bridge.sv
// Bridges single-cycle host requests onto a slow strobe bus: writes are posted
// through a small buffer, reads stall the host until the slave answers or times out.
module xt_lb_bridge
   import XT_BUS::*;
#(
   parameter int SLAVE_NUM     = 4,
   parameter int WBUF_DEPTH    = 4,
   parameter int LB_DIV        = 2,
   parameter int TIMEOUT_TICKS = 15
) (
   input  logic                    hb_clk,
   input  logic                    rst_n,
   input  hb_slave_t               xt_hb,
   input  sel_t                    sel,
   output logic [31:0]             rdata,
   output logic                    wait_finish,
   input  logic [32*SLAVE_NUM-1:0] lb_data_in,
   input  logic [SLAVE_NUM-1:0]    lb_ready_in,
   output lb_slave_t               bus,
   output logic                    lb_err,
   input  logic                    err_clr
);

   localparam int CW = (LB_DIV > 1) ? $clog2(LB_DIV) : 1;
   localparam int TW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(LB_DIV - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS);

   lb_bridge_state_e         state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [TW-1:0]            tmo_q, tmo_d;
   lb_slave_t                bus_q, bus_d;
   logic [31:0]              rdata_q, rd_val;
   logic                     lb_err_q, lb_err_d;
   logic                     rd_pending_q, rd_pending_d;
   logic [LB_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                     wr_taken_q, wr_taken_d;

   logic                     tick;
   logic                     push, pop, full, empty;
   logic                     rd_done, timeout, ready_any;
   logic [31:0]              data_or;
   wbuf_entry_t              push_entry, pop_entry;
   logic                     unused_hb_bits;

   assign unused_hb_bits = ^{xt_hb.raddr[31:LB_ADDR_WIDTH], xt_hb.waddr[31:LB_ADDR_WIDTH]};

   assign tick      = (cnt_q == DIV_LAST);
   assign cnt_d     = tick ? '0 : cnt_q + CW'(1);
   assign ready_any = |lb_ready_in;

   always_comb begin
      data_or = '0;
      for (int i = 0; i < SLAVE_NUM; i++) begin
         data_or = data_or | lb_data_in[32*i +: 32];
      end
   end

   assign push_entry = {xt_hb.waddr[LB_ADDR_WIDTH-1:0], xt_hb.wdata, xt_hb.write_width};

   xt_sync_fifo #(
      .WIDTH (WBUF_W),
      .DEPTH (WBUF_DEPTH)
   ) u_wbuf (
      .clk_i   (hb_clk),
      .rst_ni  (rst_n),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (pop_entry),
      .full_o  (full),
      .empty_o (empty)
   );

   // Low-speed side: every state change is gated by tick; buffered writes win over reads.
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      bus_d   = bus_q;
      pop     = 1'b0;
      rd_done = 1'b0;
      timeout = 1'b0;
      rd_val  = rdata_q;
      if (tick) begin
         case (state_q)
            LB_IDLE: begin
               if (!empty) begin
                  pop               = 1'b1;
                  bus_d.wen         = 1'b1;
                  bus_d.ren         = 1'b0;
                  bus_d.addr        = pop_entry.addr;
                  bus_d.wdata       = pop_entry.wdata;
                  bus_d.write_width = pop_entry.write_width;
                  tmo_d             = '0;
                  state_d           = LB_WRITE;
               end else if (rd_pending_q) begin
                  bus_d.ren  = 1'b1;
                  bus_d.wen  = 1'b0;
                  bus_d.addr = rd_addr_q;
                  tmo_d      = '0;
                  state_d    = LB_READ;
               end
            end
            LB_WRITE, LB_READ: begin
               if (ready_any || (TIMEOUT_TICKS == 0)) begin
                  bus_d.ren = 1'b0;
                  bus_d.wen = 1'b0;
                  state_d   = LB_IDLE;
                  if (state_q == LB_READ) begin
                     rd_done = 1'b1;
                     rd_val  = data_or;
                  end
               end else if ((tmo_q + TW'(1)) == TMO_LAST) begin
                  bus_d.ren = 1'b0;
                  bus_d.wen = 1'b0;
                  state_d   = LB_IDLE;
                  timeout   = 1'b1;
                  if (state_q == LB_READ) begin
                     rd_done = 1'b1;
                     rd_val  = LB_TIMEOUT_RDATA;
                  end
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
            default: state_d = LB_IDLE;
         endcase
      end
   end

   // Host side: wr_taken stops a write held across a stalled read from being pushed twice.
   always_comb begin
      wait_finish  = !((sel.wen && full && !wr_taken_q) || (sel.ren && !rd_done));
      push         = sel.wen && !full && !wr_taken_q;
      wr_taken_d   = wr_taken_q;
      rd_pending_d = rd_pending_q;
      rd_addr_d    = rd_addr_q;
      if (wait_finish) begin
         wr_taken_d = 1'b0;
      end else if (push) begin
         wr_taken_d = 1'b1;
      end
      if (rd_done) begin
         rd_pending_d = 1'b0;
      end else if (sel.ren && !rd_pending_q) begin
         rd_pending_d = 1'b1;
         rd_addr_d    = xt_hb.raddr[LB_ADDR_WIDTH-1:0];
      end
      if (timeout) begin
         lb_err_d = 1'b1;
      end else if (err_clr) begin
         lb_err_d = 1'b0;
      end else begin
         lb_err_d = lb_err_q;
      end
   end

   always_ff @(posedge hb_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= LB_IDLE;
         cnt_q        <= '0;
         tmo_q        <= '0;
         bus_q        <= '0;
         rdata_q      <= '0;
         lb_err_q     <= 1'b0;
         rd_pending_q <= 1'b0;
         rd_addr_q    <= '0;
         wr_taken_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tmo_q        <= tmo_d;
         bus_q        <= bus_d;
         rdata_q      <= rd_val;
         lb_err_q     <= lb_err_d;
         rd_pending_q <= rd_pending_d;
         rd_addr_q    <= rd_addr_d;
         wr_taken_q   <= wr_taken_d;
      end
   end

   assign rdata  = rd_val;
   assign bus    = bus_q;
   assign lb_err = lb_err_q;

endmodule
